// File: rtl/sargantana_icache_pkg.sv
// ============================================================================
// Module  : sargantana_icache_pkg
// Brief   : Shared way-count constants and replacement FSM state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sargantana_icache_pkg;

  localparam int c_ICACHE_N_WAY = 4;
  localparam int c_WAY_IDX_W    = $clog2(c_ICACHE_N_WAY);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_REFILL = 2'd1,
    UPDATE      = 2'd2
  } repl_state_t;

endpackage

`default_nettype wire

// File: rtl/sargantana_icache_replace_ctrl_if.sv
// ============================================================================
// Module  : sargantana_icache_replace_ctrl_if
// Brief   : Miss/refill handshake and victim-selection bundle of the replacer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sargantana_icache_replace_ctrl_if;
  import sargantana_icache_pkg::*;

  logic                      flush_i;
  logic                      miss_req_i;
  logic                      miss_ready_o;
  logic [c_ICACHE_N_WAY-1:0] valid_bits_i;
  logic                      refill_done_i;
  logic                      victim_valid_o;
  logic [c_WAY_IDX_W-1:0]    victim_way_o;
  logic [c_ICACHE_N_WAY-1:0] way_we_o;

  modport master (
    output flush_i, miss_req_i, valid_bits_i, refill_done_i,
    input  miss_ready_o, victim_valid_o, victim_way_o, way_we_o
  );

  modport slave (
    input  flush_i, miss_req_i, valid_bits_i, refill_done_i,
    output miss_ready_o, victim_valid_o, victim_way_o, way_we_o
  );

endinterface

`default_nettype wire

// File: rtl/sargantana_icache_tzc_idx.sv
// ============================================================================
// Module  : sargantana_icache_tzc_idx
// Brief   : Trailing-zero count: index of the lowest set bit of i_vec.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sargantana_icache_tzc_idx #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  wire logic [WIDTH-1:0] i_vec,
  output logic      [IDX_W-1:0] o_idx,
  output logic                  o_found
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sargantana_icache_replace_ctrl.sv
// ============================================================================
// Module  : sargantana_icache_replace_ctrl
// Brief   : Icache victim selection: first invalid way, else round-robin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sargantana_icache_replace_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = 4
) (
  input wire logic                        clk_i,
  input wire logic                        rstn_i,
  sargantana_icache_replace_ctrl_if.slave bus
);

  repl_state_t              r_state, w_state_nxt;
  logic [c_WAY_IDX_W-1:0]   r_rr, w_rr_nxt;
  logic [c_WAY_IDX_W-1:0]   r_victim_way, w_victim_way_nxt;
  logic                     r_victim_valid, w_victim_valid_nxt;
  logic                     r_from_rr, w_from_rr_nxt;

  logic [c_WAY_IDX_W-1:0]   w_inv_idx;
  logic                     w_inv_found;
  logic                     w_accept;
  logic                     w_we_en;

  sargantana_icache_tzc_idx #(
    .WIDTH (c_ICACHE_N_WAY),
    .IDX_W (c_WAY_IDX_W)
  ) u_tzc (
    .i_vec   (~bus.valid_bits_i),
    .o_idx   (w_inv_idx),
    .o_found (w_inv_found)
  );

  assign bus.miss_ready_o   = (r_state == IDLE);
  assign bus.victim_valid_o = r_victim_valid;
  assign bus.victim_way_o   = r_victim_way;
  assign w_accept           = bus.miss_req_i && bus.miss_ready_o && !bus.flush_i;
  assign w_we_en            = (r_state == UPDATE) && !bus.flush_i;

  always_comb begin
    for (int i = 0; i < c_ICACHE_N_WAY; i++) begin
      bus.way_we_o[i] = w_we_en && (r_victim_way == c_WAY_IDX_W'(i));
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_rr_nxt           = r_rr;
    w_victim_way_nxt   = r_victim_way;
    w_victim_valid_nxt = r_victim_valid;
    w_from_rr_nxt      = r_from_rr;
    // Flush overrides everything, including a same-cycle refill or miss.
    if (bus.flush_i) begin
      w_state_nxt        = IDLE;
      w_rr_nxt           = '0;
      w_victim_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt        = WAIT_REFILL;
            w_victim_way_nxt   = w_inv_found ? w_inv_idx : r_rr;
            w_from_rr_nxt      = !w_inv_found;
            w_victim_valid_nxt = 1'b1;
          end
        end
        WAIT_REFILL: begin
          if (bus.refill_done_i) begin
            w_state_nxt = UPDATE;
          end
        end
        UPDATE: begin
          w_state_nxt        = IDLE;
          w_victim_valid_nxt = 1'b0;
          if (r_from_rr) begin
            w_rr_nxt = r_rr + 1'b1;
          end
        end
        default: begin
          w_state_nxt        = IDLE;
          w_victim_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state        <= IDLE;
      r_rr           <= '0;
      r_victim_way   <= '0;
      r_victim_valid <= 1'b0;
      r_from_rr      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rr           <= w_rr_nxt;
      r_victim_way   <= w_victim_way_nxt;
      r_victim_valid <= w_victim_valid_nxt;
      r_from_rr      <= w_from_rr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sargantana_icache_replace_ctrl.sv
// ============================================================================
// Module  : tb_sargantana_icache_replace_ctrl
// Brief   : Directed self-checking bench for the icache replacement controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sargantana_icache_replace_ctrl;
  import sargantana_icache_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  logic [1:0] exp_q[$];
  logic [1:0] cur_victim;

  sargantana_icache_replace_ctrl_if bus ();

  sargantana_icache_replace_ctrl #(.ICACHE_N_WAY(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one miss; the expected victim goes into the scoreboard and is
  // popped once the registered selection becomes visible.
  task automatic do_miss(input string tag, input logic [3:0] vb, input logic [1:0] exp_v);
    chk({tag, "_ready"}, 32'(bus.miss_ready_o), 32'd1);
    bus.valid_bits_i = vb;
    bus.miss_req_i   = 1'b1;
    exp_q.push_back(exp_v);
    tick();
    bus.miss_req_i = 1'b0;
    chk({tag, "_vvalid"}, 32'(bus.victim_valid_o), 32'd1);
    chk({tag, "_busy"}, 32'(bus.miss_ready_o), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      cur_victim = exp_q.pop_front();
      chk({tag, "_victim"}, 32'(bus.victim_way_o), 32'(cur_victim));
    end
  endtask

  task automatic do_refill(input string tag);
    bus.refill_done_i = 1'b1;
    tick();
    bus.refill_done_i = 1'b0;
    chk({tag, "_we"}, 32'(bus.way_we_o), 32'(4'b0001 << cur_victim));
    chk({tag, "_upd_victim"}, 32'(bus.victim_way_o), 32'(cur_victim));
    tick();
    chk({tag, "_we_off"}, 32'(bus.way_we_o), 32'd0);
    chk({tag, "_idle"}, 32'(bus.miss_ready_o), 32'd1);
    chk({tag, "_vdrop"}, 32'(bus.victim_valid_o), 32'd0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    cur_victim        = 2'd0;
    rstn              = 1'b0;
    bus.flush_i       = 1'b0;
    bus.miss_req_i    = 1'b0;
    bus.valid_bits_i  = 4'b0000;
    bus.refill_done_i = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.miss_ready_o), 32'd1);
    chk("rst_vvalid", 32'(bus.victim_valid_o), 32'd0);
    chk("rst_way", 32'(bus.victim_way_o), 32'd0);
    chk("rst_we", 32'(bus.way_we_o), 32'd0);
    rstn = 1'b1;
    tick();

    // First invalid way is 2; stays stable while waiting for refill.
    do_miss("inv1011", 4'b1011, 2'd2);
    repeat (2) begin
      tick();
      chk("wait_victim", 32'(bus.victim_way_o), 32'd2);
      chk("wait_we", 32'(bus.way_we_o), 32'd0);
    end
    do_refill("inv1011");

    // Round-robin sequence with wrap; rr untouched by the invalid-way miss above.
    for (int i = 0; i < 5; i++) begin
      do_miss("rr", 4'b1111, 2'(i % 4));
      do_refill("rr");
    end

    do_miss("inv0000", 4'b0000, 2'd0);
    do_refill("inv0000");
    do_miss("inv1110", 4'b1110, 2'd0);
    do_refill("inv1110");
    do_miss("inv0111", 4'b0111, 2'd3);
    do_refill("inv0111");

    // rr is 1 here; a held miss request must not re-select.
    do_miss("hold", 4'b1111, 2'd1);
    bus.miss_req_i   = 1'b1;
    bus.valid_bits_i = 4'b0000;
    repeat (3) begin
      tick();
      chk("hold_busy", 32'(bus.miss_ready_o), 32'd0);
      chk("hold_victim", 32'(bus.victim_way_o), 32'd1);
    end
    bus.miss_req_i = 1'b0;
    do_refill("hold");

    // rr is 2: flush coinciding with refill wins and clears rr.
    do_miss("flush_rr2", 4'b1111, 2'd2);
    bus.flush_i       = 1'b1;
    bus.refill_done_i = 1'b1;
    tick();
    bus.flush_i       = 1'b0;
    bus.refill_done_i = 1'b0;
    chk("flush_we", 32'(bus.way_we_o), 32'd0);
    chk("flush_idle", 32'(bus.miss_ready_o), 32'd1);
    chk("flush_vvalid", 32'(bus.victim_valid_o), 32'd0);
    do_miss("after_flush", 4'b1111, 2'd0);

    // Flush during UPDATE suppresses the write and the rr advance.
    bus.refill_done_i = 1'b1;
    tick();
    bus.refill_done_i = 1'b0;
    bus.flush_i       = 1'b1;
    #1;
    chk("upd_flush_we", 32'(bus.way_we_o), 32'd0);
    tick();
    chk("upd_flush_idle", 32'(bus.miss_ready_o), 32'd1);

    // Flush with miss in IDLE: miss is dropped.
    bus.miss_req_i   = 1'b1;
    bus.valid_bits_i = 4'b1111;
    tick();
    bus.flush_i    = 1'b0;
    bus.miss_req_i = 1'b0;
    chk("flush_miss_ready", 32'(bus.miss_ready_o), 32'd1);
    chk("flush_miss_vvalid", 32'(bus.victim_valid_o), 32'd0);
    do_miss("rr_after_upd_flush", 4'b1111, 2'd0);
    do_refill("rr_after_upd_flush");

    // Async reset mid-replacement (rr is 1 here).
    do_miss("pre_rst", 4'b1111, 2'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", 32'(bus.miss_ready_o), 32'd1);
    chk("arst_vvalid", 32'(bus.victim_valid_o), 32'd0);
    chk("arst_way", 32'(bus.victim_way_o), 32'd0);
    chk("arst_we", 32'(bus.way_we_o), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    bus.refill_done_i = 1'b1;
    tick();
    bus.refill_done_i = 1'b0;
    chk("ign_refill_we", 32'(bus.way_we_o), 32'd0);
    chk("ign_refill_ready", 32'(bus.miss_ready_o), 32'd1);
    tick();
    chk("ign_refill_we2", 32'(bus.way_we_o), 32'd0);
    do_miss("post_rst", 4'b1111, 2'd0);
    do_refill("post_rst");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sargantana_icache_replace_ctrl.md
SARGANTANA_ICACHE_REPLACE_CTRL -- requirements
Module: sargantana_icache_replace_ctrl

Interface
REQ-001 SHALL have parameter ICACHE_N_WAY, default 4, meaning number of cache ways; only value 4 is supported.
REQ-002 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  cache flush, aborts any pending replacement.
REQ-005 SHALL have port miss_req_i  input  1  miss request valid from icache control.
REQ-006 SHALL have port miss_ready_o  output  1  controller idle, accepts miss_req_i.
REQ-007 SHALL have port valid_bits_i  input  ICACHE_N_WAY  valid bits of the indexed set, sampled at miss acceptance.
REQ-008 SHALL have port refill_done_i  input  1  refill line returned from memory, single-cycle pulse.
REQ-009 SHALL have port victim_valid_o  output  1  victim_way_o holds a valid selection.
REQ-010 SHALL have port victim_way_o  output  $clog2(ICACHE_N_WAY)  encoded victim way.
REQ-011 SHALL have port way_we_o  output  ICACHE_N_WAY  one-hot tag/data write enable for the victim way.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_REFILL, UPDATE.
REQ-013 miss_ready_o SHALL equal (state == IDLE), combinationally.
REQ-014 Acceptance SHALL be miss_req_i && miss_ready_o && !flush_i; on acceptance state -> WAIT_REFILL.
REQ-015 At acceptance, if any valid_bits_i bit is 0, victim SHALL be the lowest-index invalid way (trailing zero of ~valid_bits_i).
REQ-016 At acceptance, if all valid_bits_i bits are 1, victim SHALL be the round-robin counter value rr_q.
REQ-017 Victim SHALL be registered; victim_way_o and victim_valid_o=1 SHALL appear the cycle after acceptance (latency 1) and hold stable through WAIT_REFILL and UPDATE.
REQ-018 In WAIT_REFILL, refill_done_i=1 and flush_i=0 SHALL move state -> UPDATE; otherwise remain.
REQ-019 In UPDATE, way_we_o SHALL equal one-hot of victim_way_o for exactly one cycle; state -> IDLE next cycle.
REQ-020 way_we_o SHALL be all-zero in every state other than UPDATE.
REQ-021 rr_q SHALL increment by 1 modulo ICACHE_N_WAY (3 -> 0 wrap) on the UPDATE cycle only when the victim came from rr_q (all ways valid at acceptance).
REQ-022 rr_q SHALL NOT change when the victim was an invalid way.
REQ-023 victim_valid_o SHALL drop to 0 in the cycle the FSM re-enters IDLE.
REQ-024 flush_i=1 in any state SHALL force state -> IDLE next cycle, clear victim_valid_o, reset rr_q to 0, and suppress way_we_o in that cycle.
REQ-025 flush_i and refill_done_i asserted together SHALL resolve as flush (no write).
REQ-026 flush_i and miss_req_i asserted together in IDLE SHALL resolve as flush (miss not accepted).
REQ-027 refill_done_i in IDLE or UPDATE SHALL be ignored.
REQ-028 miss_req_i while not IDLE SHALL be ignored (not queued).

Reset
REQ-029 rstn_i low SHALL immediately force state=IDLE, rr_q=0, victim_way_o=0, victim_valid_o=0, way_we_o=0; miss_ready_o=1 consequently.
REQ-030 Reset asserted mid-replacement SHALL discard the pending victim with no write enable issued.

Structure
REQ-031 FSM state enum and ICACHE_N_WAY-derived way index width SHALL live in sargantana_icache_pkg.
REQ-032 Invalid-way selection SHALL instantiate one sub-module, sargantana_icache_tzc_idx, on ~valid_bits_i.
REQ-033 All registers SHALL use a single always_ff on posedge clk_i / negedge rstn_i.

Verification
REQ-034 Valid 4'b1011, miss_req -> next cycle victim_way_o=2, victim_valid_o=1; refill_done -> way_we_o=4'b0100 one cycle; rr_q stays 0.
REQ-035 Four consecutive misses with valid 4'b1111, each refilled -> victims 0,1,2,3; fifth miss -> victim 0 (wrap).
REQ-036 Valid 4'b0000 -> victim 0; valid 4'b1110 -> victim 0; valid 4'b0111 -> victim 3.
REQ-037 Miss accepted (rr_q=2), flush_i with refill_done_i same cycle -> way_we_o=0, IDLE next cycle, rr_q=0.
REQ-038 rstn_i low asynchronously during WAIT_REFILL -> outputs zero immediately, miss_ready_o=1, later refill_done_i ignored.
REQ-039 miss_req_i held high during WAIT_REFILL -> no second acceptance; victim_way_o unchanged until UPDATE completes.
